time_display_mux: RTL and testbench

Downstream consumer of the 1 Hz time-of-day counter: takes its binary `seconds`, `minutes` and `hours` outputs and drives a six-digit, common-anode, time-multiplexed 7-segment display (HH MM SS) from the fast system clock. It contains:
- a refresh divider and a digit-scan counter;
- a tear-free input snapshot;
- binary-to-BCD split, segment encoding and registered pad outputs.

---
 rtl/time_display_mux.sv | 159 +++++++++++++++
 tb/tb_time_display_mux.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/time_display_mux.sv
// Six-digit multiplexed HH:MM:SS 7-segment driver with per-frame input snapshot.
// Define TIME_DISPLAY_12H_EN for 12-hour display with PM indicator on digit 5.
module time_display_mux #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned SCAN_HZ = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] an_n
);

  // DIV must be at least 2 for the scan to make sense.
  localparam int unsigned DIV = CLK_HZ / (SCAN_HZ * 6);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegDash  = 7'b0111111;

  logic [CW-1:0] div_cnt_q;
  logic [2:0]    idx_q;
  logic          valid_q;
  logic [5:0]    sec_q, min_q;
  logic [4:0]    hr_q;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [5:0]    an_q, an_d;
  logic          tick;

  assign tick = (div_cnt_q == CW'(DIV - 1));

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    if (v >= 6'd50)      return 4'd5;
    else if (v >= 6'd40) return 4'd4;
    else if (v >= 6'd30) return 4'd3;
    else if (v >= 6'd20) return 4'd2;
    else if (v >= 6'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  function automatic logic [3:0] ones_of(input logic [5:0] v);
    logic [5:0] r;
    r = v - (6'(tens_of(v)) * 6'd10);
    return r[3:0];
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SegBlank;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      idx_q     <= 3'd5;
      valid_q   <= 1'b0;
      sec_q     <= '0;
      min_q     <= '0;
      hr_q      <= '0;
      seg_q     <= SegBlank;
      dp_q      <= 1'b1;
      an_q      <= 6'b111111;
    end else begin
      div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
      if (tick) begin
        valid_q <= 1'b1;
        if (idx_q == 3'd5) begin
          idx_q <= 3'd0;
          sec_q <= seconds;
          min_q <= minutes;
          hr_q  <= hours;
        end else begin
          idx_q <= idx_q + 3'd1;
        end
      end
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  logic [4:0] hr_disp;
  logic [3:0] h_tens, h_ones, m_tens, m_ones, s_tens, s_ones;
  logic       hr_bad, min_bad, sec_bad;

  always_comb begin
    hr_disp = hr_q;
`ifdef TIME_DISPLAY_12H_EN
    if (hr_q == 5'd0)                         hr_disp = 5'd12;
    else if (hr_q >= 5'd13 && hr_q <= 5'd23)  hr_disp = hr_q - 5'd12;
`endif
    h_tens  = tens_of({1'b0, hr_disp});
    h_ones  = ones_of({1'b0, hr_disp});
    m_tens  = tens_of(min_q);
    m_ones  = ones_of(min_q);
    s_tens  = tens_of(sec_q);
    s_ones  = ones_of(sec_q);
    hr_bad  = (hr_q >= 5'd24);
    min_bad = (min_q >= 6'd60);
    sec_bad = (sec_q >= 6'd60);
  end

  logic [3:0] digit;
  logic       dash, blank;

  always_comb begin
    digit = 4'd0;
    dash  = 1'b0;
    blank = 1'b0;
    case (idx_q)
      3'd0: begin
        digit = h_tens;
        dash  = hr_bad;
`ifdef TIME_DISPLAY_12H_EN
        blank = (h_tens == 4'd0);
`endif
      end
      3'd1:    begin digit = h_ones; dash = hr_bad;  end
      3'd2:    begin digit = m_tens; dash = min_bad; end
      3'd3:    begin digit = m_ones; dash = min_bad; end
      3'd4:    begin digit = s_tens; dash = sec_bad; end
      default: begin digit = s_ones; dash = sec_bad; end
    endcase

    seg_d = SegBlank;
    dp_d  = 1'b1;
    an_d  = 6'b111111;
    if (valid_q) begin
      an_d = ~(6'b000001 << idx_q);
      if (dash)        seg_d = SegDash;
      else if (!blank) seg_d = seg7(digit);
      // Colon blinks at 1 Hz from the seconds LSB.
      if ((idx_q == 3'd1 || idx_q == 3'd3) && !sec_q[0]) dp_d = 1'b0;
`ifdef TIME_DISPLAY_12H_EN
      if (idx_q == 3'd5 && hr_q >= 5'd12) dp_d = 1'b0;
`endif
    end
  end

  assign seg_n = seg_q;
  assign dp_n  = dp_q;
  assign an_n  = an_q;

endmodule

// File: tb/tb_time_display_mux.sv
// Directed bench for time_display_mux at DIV = 10; honours TIME_DISPLAY_12H_EN.
module tb_time_display_mux;

  localparam int DIV = 10;

`ifdef TIME_DISPLAY_12H_EN
  localparam bit H12 = 1'b1;
`else
  localparam bit H12 = 1'b0;
`endif

  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100,
                         D3 = 7'b0110000, D4 = 7'b0011001, D5 = 7'b0010010,
                         D7 = 7'b1111000, D8 = 7'b0000000, D9 = 7'b0010000,
                         BL = 7'b1111111, DASH = 7'b0111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] seconds, minutes;
  logic [4:0] hours;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] an_n;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] exp_seg [6];
  logic [5:0] exp_dp;

  time_display_mux #(
    .CLK_HZ (600),
    .SCAN_HZ(10)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .seconds(seconds),
    .minutes(minutes),
    .hours  (hours),
    .seg_n  (seg_n),
    .dp_n   (dp_n),
    .an_n   (an_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b, want %b", tag, got, want);
    end
  endtask

  task automatic set_exp(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                         input logic [6:0] d, input logic [6:0] e, input logic [6:0] f,
                         input logic [5:0] dp);
    exp_seg[0] = a; exp_seg[1] = b; exp_seg[2] = c;
    exp_seg[3] = d; exp_seg[4] = e; exp_seg[5] = f;
    exp_dp     = dp;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hours   = 5'(h);
    minutes = 6'(m);
    seconds = 6'(s);
  endtask

  task automatic tick_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at the start of digit 'first'; leaves the bench at the start of digit last+1.
  task automatic show_digits(input int first, input int last);
    logic [5:0] sel;
    for (int d = first; d <= last; d++) begin
      sel = ~(6'b000001 << d);
      check($sformatf("an_n digit %0d", d), {2'b0, an_n}, {2'b0, sel});
      check($sformatf("seg_n digit %0d", d), {1'b0, seg_n}, {1'b0, exp_seg[d]});
      check($sformatf("dp_n digit %0d", d), {7'b0, dp_n}, {7'b0, exp_dp[d]});
      tick_cycles(DIV - 1);
      check($sformatf("an_n hold digit %0d", d), {2'b0, an_n}, {2'b0, sel});
      tick_cycles(1);
    end
  endtask

  task automatic check_reset_outputs();
    check("reset an_n", {2'b0, an_n}, 8'h3F);
    check("reset seg_n", {1'b0, seg_n}, 8'h7F);
    check("reset dp_n", {7'b0, dp_n}, 8'h01);
  endtask

  // Entered one cycle after the reset edge with reset just released.
  task automatic expect_startup();
    int blank_bad;
    blank_bad = 0;
    for (int i = 1; i <= DIV; i++) begin
      tick_cycles(1);
      if (an_n !== 6'b111111 || seg_n !== 7'h7F) blank_bad++;
    end
    check("startup blank cycles bad", 8'(blank_bad), 8'd0);
    tick_cycles(1);
    check("first digit select", {2'b0, an_n}, 8'b0011_1110);
  endtask

  initial begin
    reset = 1'b1;
    set_time(23, 59, 58);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    expect_startup();

    // 23:59:58
    if (H12) set_exp(D1, D1, D5, D9, D5, D8, 6'b010101);
    else     set_exp(D2, D3, D5, D9, D5, D8, 6'b110101);
    show_digits(0, 5);

    // Inputs change right after the snapshot: this frame still shows the old time.
    set_time(12, 34, 57);
    show_digits(0, 5);

    if (H12) set_exp(D1, D2, D3, D4, D5, D7, 6'b011111);
    else     set_exp(D1, D2, D3, D4, D5, D7, 6'b111111);
    show_digits(0, 2);
    set_time(12, 34, 58);
    show_digits(3, 5);

    if (H12) set_exp(D1, D2, D3, D4, D5, D8, 6'b010101);
    else     set_exp(D1, D2, D3, D4, D5, D8, 6'b110101);
    show_digits(0, 5);

    // Out-of-range seconds.
    set_time(7, 5, 61);
    tick_cycles(6 * DIV);
    if (H12) set_exp(BL, D7, D0, D5, DASH, DASH, 6'b111111);
    else     set_exp(D0, D7, D0, D5, DASH, DASH, 6'b111111);
    show_digits(0, 5);

    set_time(0, 0, 0);
    tick_cycles(6 * DIV);
    if (H12) set_exp(D1, D2, D0, D0, D0, D0, 6'b110101);
    else     set_exp(D0, D0, D0, D0, D0, D0, 6'b110101);
    show_digits(0, 5);

    set_time(15, 0, 0);
    tick_cycles(6 * DIV);
    if (H12) set_exp(BL, D3, D0, D0, D0, D0, 6'b010101);
    else     set_exp(D1, D5, D0, D0, D0, D0, 6'b110101);
    show_digits(0, 5);

    // Out-of-range hours and minutes.
    set_time(25, 60, 10);
    tick_cycles(6 * DIV);
    if (H12) set_exp(DASH, DASH, DASH, DASH, D1, D0, 6'b010101);
    else     set_exp(DASH, DASH, DASH, DASH, D1, D0, 6'b110101);
    show_digits(0, 5);

    // Reset while digit 3 is on the pads.
    show_digits(0, 2);
    check("an_n before mid reset", {2'b0, an_n}, 8'b0011_0111);
    reset = 1'b1;
    tick_cycles(1);
    check_reset_outputs();
    reset = 1'b0;
    expect_startup();
    show_digits(0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
